// File: rtl/backprop_update.sv
// Backward-pass neuron update: delta = (target - prediction) * f'(.), then streams w' = w + lr*delta*x.
// Narrowing clamps when BACKPROP_SATURATE_EN is defined, otherwise wraps to WIDTH bits.

package backprop_pkg;
  typedef enum logic [2:0] {
    ACT_STEP    = 3'd0,
    ACT_SIGMOID = 3'd1,
    ACT_TANH    = 3'd2,
    ACT_RELU    = 3'd3,
    ACT_LINEAR  = 3'd4
  } act_func;
endpackage

module backprop_update
  import backprop_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int N_INPUTS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  act_func                 activation,
  input  logic signed [WIDTH-1:0] sum,
  input  logic signed [WIDTH-1:0] prediction,
  input  logic signed [WIDTH-1:0] target,
  input  logic signed [WIDTH-1:0] lr,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] w_in,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic signed [WIDTH-1:0] w_out,
  output logic                    w_last,
  output logic signed [WIDTH-1:0] delta,
  output logic                    busy
);

`ifdef BACKPROP_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int unsigned CW = $clog2(N_INPUTS + 1);
  localparam logic [CW-1:0] N_C    = CW'(N_INPUTS);
  localparam logic [CW-1:0] LAST_C = CW'(N_INPUTS - 1);

  localparam logic signed [WIDTH-1:0]   ONE  = WIDTH'(64'd1 << FRAC);
  localparam logic signed [WIDTH-1:0]   SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]   SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] RND  = (2*WIDTH)'(64'd1 << (FRAC - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_DERIV,
    S_DELTA,
    S_SCALE,
    S_STREAM
  } state_t;

  state_t state, state_next;

  act_func                 act_r;
  logic signed [WIDTH-1:0] sum_r, pred_r, tgt_r, lr_r;
  logic signed [WIDTH-1:0] err_r, fp_r, g_r, fp_next;
  logic [CW-1:0]           in_cnt, out_cnt;
  logic                    accept, drain;

  function automatic logic signed [WIDTH-1:0] narrow_sum(input logic signed [WIDTH:0] s);
    if (SAT && (s[WIDTH] != s[WIDTH-1])) return s[WIDTH] ? SMIN : SMAX;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] narrow_prod(input logic signed [2*WIDTH-1:0] p);
    if (SAT && (p > PMAX)) return SMAX;
    if (SAT && (p < PMIN)) return SMIN;
    return p[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] fx_add(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
    return narrow_sum({a[WIDTH-1], a} + {b[WIDTH-1], b});
  endfunction

  function automatic logic signed [WIDTH-1:0] fx_sub(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
    return narrow_sum({a[WIDTH-1], a} - {b[WIDTH-1], b});
  endfunction

  // Sign-extended operands make the 2W-bit modular product equal the signed product.
  function automatic logic signed [WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
    logic [2*WIDTH-1:0]        ae, be;
    logic signed [2*WIDTH-1:0] p;
    ae = {{WIDTH{a[WIDTH-1]}}, a};
    be = {{WIDTH{b[WIDTH-1]}}, b};
    p  = $signed(ae * be) + RND;
    p  = p >>> FRAC;
    return narrow_prod(p);
  endfunction

  always_comb begin
    fp_next = ONE;
    case (act_r)
      ACT_SIGMOID: fp_next = fx_mul(pred_r, fx_sub(ONE, pred_r));
      ACT_TANH:    fp_next = fx_sub(ONE, fx_mul(pred_r, pred_r));
      ACT_RELU:    fp_next = (!sum_r[WIDTH-1] && (sum_r != '0)) ? ONE : '0;
      default:     fp_next = ONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    busy        = 1'b1;
    x_ready     = 1'b0;
    accept      = 1'b0;
    drain       = 1'b0;
    case (state)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) state_next = S_DERIV;
      end
      S_DERIV: state_next = S_DELTA;
      S_DELTA: state_next = S_SCALE;
      S_SCALE: state_next = S_STREAM;
      S_STREAM: begin
        x_ready = (in_cnt < N_C) && (!w_valid || w_ready);
        accept  = x_valid && x_ready;
        drain   = w_valid && w_ready;
        if (drain && (out_cnt == LAST_C)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_r   <= ACT_STEP;
      sum_r   <= '0;
      pred_r  <= '0;
      tgt_r   <= '0;
      lr_r    <= '0;
      err_r   <= '0;
      fp_r    <= '0;
      g_r     <= '0;
      delta   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      w_out   <= '0;
      w_valid <= 1'b0;
      w_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            act_r  <= activation;
            sum_r  <= sum;
            pred_r <= prediction;
            tgt_r  <= target;
            lr_r   <= lr;
          end
        end
        S_DERIV: begin
          err_r <= fx_sub(tgt_r, pred_r);
          fp_r  <= fp_next;
        end
        S_DELTA: delta <= fx_mul(err_r, fp_r);
        S_SCALE: begin
          g_r     <= fx_mul(lr_r, delta);
          in_cnt  <= '0;
          out_cnt <= '0;
        end
        S_STREAM: begin
          // A new pair may load in the same cycle the previous output drains.
          if (accept) begin
            w_out   <= fx_add(w_in, fx_mul(g_r, x));
            w_valid <= 1'b1;
            w_last  <= (in_cnt == LAST_C);
            in_cnt  <= in_cnt + CW'(1);
          end else if (drain) begin
            w_valid <= 1'b0;
            w_last  <= 1'b0;
          end
          if (drain) out_cnt <= out_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_backprop_update.sv
// Self-checking bench for backprop_update: directed test-plan cases plus randomized samples
// checked against an arithmetic reference model of the update rule.

module tb_backprop_update;
  import backprop_pkg::*;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int N     = 4;
  localparam longint ONE = 256;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start_valid, start_ready;
  act_func                 activation;
  logic signed [WIDTH-1:0] sum, prediction, target, lr;
  logic                    x_valid, x_ready;
  logic signed [WIDTH-1:0] x, w_in;
  logic                    w_valid, w_ready;
  logic signed [WIDTH-1:0] w_out;
  logic                    w_last;
  logic signed [WIDTH-1:0] delta;
  logic                    busy;

  int tests = 0;
  int fails = 0;
  longint got [N];

  backprop_update #(.WIDTH(WIDTH), .FRAC(FRAC), .N_INPUTS(N)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .activation(activation), .sum(sum), .prediction(prediction),
    .target(target), .lr(lr),
    .x_valid(x_valid), .x_ready(x_ready), .x(x), .w_in(w_in),
    .w_valid(w_valid), .w_ready(w_ready), .w_out(w_out), .w_last(w_last),
    .delta(delta), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic longint nar(input longint v);
    longint lim, m;
    lim = longint'(1) << (WIDTH - 1);
`ifdef BACKPROP_SATURATE_EN
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
`else
    m = v & ((lim << 1) - 1);
    if (m >= lim) m = m - (lim << 1);
    return m;
`endif
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return nar((a * b + (longint'(1) << (FRAC - 1))) >>> FRAC);
  endfunction

  function automatic longint rnd16();
    return longint'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic run_sample(input int act, input longint s, input longint p, input longint t,
                            input longint l, input longint xs [N], input longint ws [N],
                            input bit rnd, input int stall_at, input int abort_after);
    longint err, fp, dl, g;
    longint ex [N];
    int out_idx, in_idx, cyc, stall_left;
    bit acc, drn, aborted;

    err = nar(t - p);
    case (act)
      0: fp = ONE;
      1: fp = fmul(p, nar(ONE - p));
      2: fp = nar(ONE - fmul(p, p));
      3: fp = (s > 0) ? ONE : 0;
      default: fp = ONE;
    endcase
    dl = fmul(err, fp);
    g  = fmul(l, dl);
    for (int i = 0; i < N; i++) ex[i] = nar(ws[i] + fmul(g, xs[i]));

    @(negedge clk);
    activation  = act_func'(act[2:0]);
    sum         = s[WIDTH-1:0];
    prediction  = p[WIDTH-1:0];
    target      = t[WIDTH-1:0];
    lr          = l[WIDTH-1:0];
    start_valid = 1'b1;
    x_valid     = 1'b0;
    w_ready     = 1'b1;
    #1 chk("start_ready_idle", start_ready, 1);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    activation  = act_func'(3'($urandom));
    sum         = 16'($urandom);
    prediction  = 16'($urandom);
    target      = 16'($urandom);
    lr          = 16'($urandom);
    #1;
    chk("busy_deriv", busy, 1);
    chk("start_ready_busy", start_ready, 0);
    chk("x_ready_t1", x_ready, 0);
    @(negedge clk); #1 chk("x_ready_t2", x_ready, 0);
    @(negedge clk); #1 chk("x_ready_t3", x_ready, 0);
    chk("delta_t3", delta, dl);
    @(negedge clk); #1 chk("x_ready_t4", x_ready, 1);

    out_idx = 0; in_idx = 0; cyc = 0; stall_left = 3; aborted = 1'b0;
    while (out_idx < N && cyc < 200) begin
      x_valid = (in_idx < N) && (!rnd || $urandom_range(0, 3) != 0);
      x       = (in_idx < N) ? xs[in_idx][WIDTH-1:0] : '0;
      w_in    = (in_idx < N) ? ws[in_idx][WIDTH-1:0] : '0;
      if (w_valid && out_idx == stall_at && stall_left > 0) begin
        w_ready = 1'b0;
        stall_left--;
      end else begin
        w_ready = !rnd || ($urandom_range(0, 2) != 0);
      end
      #1;
      if (w_valid && !w_ready) begin
        chk("stall_x_ready", x_ready, 0);
        chk("stall_w_out", w_out, ex[out_idx]);
        chk("stall_w_last", w_last, (out_idx == N - 1));
      end
      acc = x_valid && x_ready;
      drn = w_valid && w_ready;
      if (drn) begin
        chk("w_out", w_out, ex[out_idx]);
        chk("w_last", w_last, (out_idx == N - 1));
        got[out_idx] = longint'(w_out);
        out_idx++;
      end
      if (acc) in_idx++;
      @(posedge clk);
      if (abort_after >= 0 && out_idx == abort_after) begin
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    x_valid = 1'b0;

    if (!aborted) begin
      chk("output_count", out_idx, N);
      @(negedge clk); #1;
      chk("busy_after", busy, 0);
      chk("start_ready_after", start_ready, 1);
      chk("w_valid_after", w_valid, 0);
    end
  endtask

  initial begin
    int act;
    longint s, p, t, l;
    longint xs [N];
    longint ws [N];

    rst = 1'b1; start_valid = 1'b0; activation = ACT_STEP;
    sum = '0; prediction = '0; target = '0; lr = '0;
    x_valid = 1'b0; x = '0; w_in = '0; w_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_x_ready", x_ready, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_last", w_last, 0);
    chk("rst_w_out", w_out, 0);
    chk("rst_delta", delta, 0);
    rst = 1'b0;

    // Sigmoid
    run_sample(1, 100, 192, 256, 256, '{256, 128, -300, 77}, '{0, 50, 1000, -20}, 0, -1, -1);
    chk("sig_delta", delta, 12);
    chk("sig_w0", got[0], 12);

    // Step
    run_sample(0, 0, 0, 256, 128, '{512, 256, -256, 0}, '{256, 0, 10, -5}, 0, -1, -1);
    chk("step_delta", delta, 256);
    chk("step_w0", got[0], 512);

    // ReLU with negative sum passes weights through
    run_sample(3, -5, 300, -700, 256, '{1234, -999, 31000, 7}, '{100, -7, 0, 3000}, 0, -1, -1);
    chk("relu_w0", got[0], 100);
    chk("relu_w1", got[1], -7);
    chk("relu_w2", got[2], 0);
    chk("relu_w3", got[3], 3000);

    // Overflow on the weight sum
    run_sample(0, 0, 0, 256, 256, '{2560, 0, 0, 0}, '{32000, 1, 2, 3}, 0, -1, -1);
`ifdef BACKPROP_SATURATE_EN
    chk("ovf_w0", got[0], 32767);
`else
    chk("ovf_w0", got[0], -30976);
`endif

    // Consumer stall mid-stream
    run_sample(2, 40, 100, 300, 200, '{300, -400, 500, -600}, '{11, 22, 33, 44}, 0, 1, -1);

    // Reset after the second output, then a fresh sample
    run_sample(0, 0, 0, 256, 256, '{256, 256, 256, 256}, '{1, 2, 3, 4}, 0, -1, 2);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_w_valid", w_valid, 0);
    chk("abort_delta", delta, 0);
    chk("abort_start_ready", start_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    run_sample(4, 0, -100, 100, 64, '{256, 512, -256, 1000}, '{5, 6, 7, 8}, 0, -1, -1);

    // Randomized samples with gaps and back-pressure
    for (int k = 0; k < 12; k++) begin
      act = int'($urandom_range(0, 7));
      s   = rnd16();
      p   = longint'($urandom_range(0, 800)) - 400;
      t   = longint'($urandom_range(0, 800)) - 400;
      l   = longint'($urandom_range(0, 1024)) - 512;
      for (int i = 0; i < N; i++) begin
        xs[i] = rnd16();
        ws[i] = rnd16();
      end
      run_sample(act, s, p, t, l, xs, ws, 1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
